// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the EXE-stage divide controller.
//   DIV_ITER     : iteration count of the restoring divider (operand width)
//   div_state_e  : controller states IDLE / CALC / DONE
//   DIV_OP_*     : encodings of the div_op field
//   magnitude()  : absolute value for signed operands (0x80000000 maps to itself)
//   apply_sign() : two's complement negation when a sign flag is set
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DIV_ITER = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Bit 0 picks quotient (0) or remainder (1); bit 1 set means unsigned.
   localparam logic [1:0] DIV_OP_DIV_W  = 2'b00;
   localparam logic [1:0] DIV_OP_MOD_W  = 2'b01;
   localparam logic [1:0] DIV_OP_DIV_WU = 2'b10;
   localparam logic [1:0] DIV_OP_MOD_WU = 2'b11;

   // Negating 0x80000000 wraps back to 0x80000000, which is exactly the
   // unsigned magnitude the divider needs for the most negative operand.
   function automatic logic [31:0] magnitude(input logic [31:0] value,
                                             input logic        is_signed);
      return (is_signed && value[31]) ? (~value + 32'd1) : value;
   endfunction

   function automatic logic [31:0] apply_sign(input logic [31:0] value,
                                              input logic        negate);
      return negate ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/exe_div_ctrl_if.sv
// ----------------------------------------------------------------------------
// exe_div_ctrl_if
// Handshake/bus bundle between the EXE stage and the divide controller.
//   exe_valid, div_req, div_op, src1, src2 : instruction held in EXE
//   cancel                                 : abort the divide in flight
//   mem_allow_in                           : MEM accepts the EXE instruction
//   div_ready_go                           : ANDed into EXE ready_go
//   div_result                             : quotient or remainder
//   busy                                   : divider iterating
// master = pipeline side, slave = divide controller.
// ----------------------------------------------------------------------------
interface exe_div_ctrl_if;

   logic        exe_valid;
   logic        div_req;
   logic [1:0]  div_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        cancel;
   logic        mem_allow_in;
   logic        div_ready_go;
   logic [31:0] div_result;
   logic        busy;

   modport master (
      output exe_valid, div_req, div_op, src1, src2, cancel, mem_allow_in,
      input  div_ready_go, div_result, busy
   );

   modport slave (
      input  exe_valid, div_req, div_op, src1, src2, cancel, mem_allow_in,
      output div_ready_go, div_result, busy
   );

endinterface

// File: rtl/div_core.sv
// ----------------------------------------------------------------------------
// div_core
// Restoring-division datapath: a 64-bit {rem, quo} shift register, the
// latched divisor magnitude and a 5-bit iteration counter.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture dividend/divisor magnitudes, clear rem and counter
//   step       : perform one shift/trial-subtract iteration
//   dividend   : unsigned dividend magnitude
//   divisor    : unsigned divisor magnitude
//   quo, rem   : register contents advanced by the iteration in progress,
//                so on the final step they already hold the finished result
//   last       : the iteration in progress is the final one
// ----------------------------------------------------------------------------
module div_core
   import cpu_pkg::*;
#(
   parameter int ITER = DIV_ITER
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quo,
   output logic [31:0] rem,
   output logic        last
);

   localparam logic [4:0] LAST_COUNT = 5'(ITER - 1);

   logic [31:0] quo_q;
   logic [31:0] rem_q;
   logic [31:0] divisor_q;
   logic [4:0]  count_q;
   logic [32:0] partial;
   logic [32:0] trial;

   // One restoring iteration. The shifted partial remainder is the upper
   // 33 bits of {rem, quo} << 1. A clear sign bit on the trial difference
   // means the divisor fits, so the difference is kept and a 1 shifts into
   // the quotient. Otherwise the shifted value is kept unchanged; it is then
   // below the divisor and therefore fits back into 32 bits.
   always_comb begin
      partial = {rem_q, quo_q[31]};
      trial   = partial - {1'b0, divisor_q};
      if (!trial[32]) begin
         rem = trial[31:0];
         quo = {quo_q[30:0], 1'b1};
      end else begin
         rem = partial[31:0];
         quo = {quo_q[30:0], 1'b0};
      end
   end

   assign last = (count_q == LAST_COUNT);

   // Shift register and counter. A load starts a fresh division from a zero
   // remainder. Every step commits the iteration computed above and advances
   // the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q     <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         count_q   <= '0;
      end else if (load) begin
         quo_q     <= dividend;
         rem_q     <= '0;
         divisor_q <= divisor;
         count_q   <= '0;
      end else if (step) begin
         quo_q     <= quo;
         rem_q     <= rem;
         count_q   <= count_q + 5'd1;
      end
   end

endmodule

// File: rtl/exe_div_ctrl.sv
// ----------------------------------------------------------------------------
// exe_div_ctrl
// Sequencing controller for the iterative 32-bit divider in the EXE stage.
// It holds a divide instruction in EXE (by pulling div_ready_go low) while
// div_core runs 32 restoring iterations, then presents the sign-corrected
// quotient or remainder until MEM accepts the instruction.
//   clk, reset : clock and synchronous active-high reset
//   bus        : exe_div_ctrl_if slave port
//                in : exe_valid, div_req, div_op, src1, src2, cancel,
//                     mem_allow_in
//                out: div_ready_go, div_result, busy
// ----------------------------------------------------------------------------
module exe_div_ctrl
   import cpu_pkg::*;
#(
   parameter int ITER = DIV_ITER
) (
   input  logic           clk,
   input  logic           reset,
   exe_div_ctrl_if.slave  bus
);

   div_state_e  state;
   logic [1:0]  op_q;
   logic        quo_neg_q;
   logic        rem_neg_q;
   logic        div_zero_q;
   logic [31:0] src1_q;
   logic [31:0] result_q;

   logic        div_seen;
   logic        signed_op;
   logic        load;
   logic        step;
   logic        last;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] final_result;

   assign div_seen  = bus.exe_valid & bus.div_req;
   assign signed_op = ~bus.div_op[1];
   assign load      = (state == IDLE) & div_seen & ~bus.cancel;
   assign step      = (state == CALC) & ~bus.cancel;

   div_core #(
      .ITER     (ITER)
   ) u_div_core (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .step     (step),
      .dividend (magnitude(bus.src1, signed_op)),
      .divisor  (magnitude(bus.src2, signed_op)),
      .quo      (quo),
      .rem      (rem),
      .last     (last)
   );

   // Result selection from the latched op and flags. Division by zero is
   // fixed up explicitly: div ops answer all ones and mod ops hand back the
   // original dividend without sign correction. Signed overflow needs no
   // special case because the magnitude algorithm already gives 0x80000000.
   always_comb begin
      final_result = '0;
      if (div_zero_q) begin
         final_result = op_q[0] ? src1_q : 32'hFFFF_FFFF;
      end else if (op_q[0]) begin
         final_result = apply_sign(rem, rem_neg_q);
      end else begin
         final_result = apply_sign(quo, quo_neg_q);
      end
   end

   // Controller FSM. cancel outranks every transition and simply drops back
   // to IDLE, which discards the partial division. The result register is
   // loaded on the final CALC step, so it is already valid on the first DONE
   // cycle and holds steady for as long as MEM stalls. Leaving DONE happens
   // on the same edge that EXE loads its next instruction, so the finished
   // divide is never restarted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op_q       <= '0;
         quo_neg_q  <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         src1_q     <= '0;
         result_q   <= '0;
      end else if (bus.cancel) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (div_seen) begin
                  op_q       <= bus.div_op;
                  quo_neg_q  <= signed_op & (bus.src1[31] ^ bus.src2[31]);
                  rem_neg_q  <= signed_op & bus.src1[31];
                  div_zero_q <= (bus.src2 == 32'd0);
                  src1_q     <= bus.src1;
                  state      <= CALC;
               end
            end
            CALC: begin
               if (last) begin
                  result_q <= final_result;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (bus.mem_allow_in) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Stage gating. In IDLE a divide sitting in EXE must wait, anything else
   // passes through with no added latency. CALC always stalls, DONE lets the
   // instruction go.
   always_comb begin
      bus.div_ready_go = 1'b1;
      case (state)
         IDLE:    bus.div_ready_go = ~div_seen;
         CALC:    bus.div_ready_go = 1'b0;
         DONE:    bus.div_ready_go = 1'b1;
         default: bus.div_ready_go = 1'b1;
      endcase
   end

   assign bus.busy       = (state == CALC);
   assign bus.div_result = result_q;

   // The operands must stay in EXE for the whole division; only cancel may
   // take the request away while iterating.
   a_req_held_in_calc : assert property (
      @(posedge clk) disable iff (reset)
      (state == CALC && !bus.cancel) |-> (bus.exe_valid && bus.div_req)
   );

endmodule

// File: tb/tb_exe_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exe_div_ctrl
// Self-checking bench for exe_div_ctrl: directed divides with hand-computed
// results, plus a timestamp-based reference model that checks busy,
// div_ready_go and div_result on every cycle.
// ----------------------------------------------------------------------------
module tb_exe_div_ctrl;

   import cpu_pkg::*;

   logic clk = 1'b0;
   logic reset;

   exe_div_ctrl_if bus ();

   exe_div_ctrl #(
      .ITER  (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: m_age counts cycles since the request was first seen,
   // so ages 1..32 are iterations and age 33 onward is result presentation.
   bit          m_active  = 1'b0;
   int          m_age     = 0;
   logic [31:0] m_pending = '0;
   logic [31:0] m_result  = '0;

   // Architectural answer of a divide-class instruction, from plain 64-bit
   // arithmetic (truncating division, remainder takes the dividend's sign).
   function automatic logic [31:0] modelResult(input logic [1:0]  op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) begin
         return op[0] ? a : 32'hFFFF_FFFF;
      end
      if (!op[1]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return op[0] ? r[31:0] : q[31:0];
   endfunction

   task automatic checkOutput(input string       name,
                              input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Model update on each rising edge from the inputs driven during the cycle.
   always @(posedge clk) begin
      if (reset) begin
         m_active <= 1'b0;
         m_age    <= 0;
         m_result <= '0;
      end else if (bus.cancel) begin
         m_active <= 1'b0;
      end else if (!m_active) begin
         if (bus.exe_valid && bus.div_req) begin
            m_active  <= 1'b1;
            m_age     <= 1;
            m_pending <= modelResult(bus.div_op, bus.src1, bus.src2);
         end
      end else if (m_age < 33) begin
         m_age <= m_age + 1;
         if (m_age == 32) begin
            m_result <= m_pending;
         end
      end else if (bus.mem_allow_in) begin
         m_active <= 1'b0;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("cycle busy", 32'(bus.busy), 32'(m_active && m_age <= 32));
         checkOutput("cycle ready_go", 32'(bus.div_ready_go),
                     32'(m_active ? (m_age >= 33) : !(bus.exe_valid && bus.div_req)));
         if (m_active && m_age >= 33) begin
            checkOutput("cycle div_result", bus.div_result, m_result);
         end
      end
   end

   task automatic startDiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.exe_valid    = 1'b1;
      bus.div_req      = 1'b1;
      bus.div_op       = op;
      bus.src1         = a;
      bus.src2         = b;
      bus.mem_allow_in = 1'b0;
   endtask

   // Counts negedges from the given cycle number until div_ready_go rises.
   task automatic waitDone(input int start, input string name);
      int  n    = start;
      bit  seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk);
         if (bus.div_ready_go) seen = 1'b1;
         else n++;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: got no div_ready_go, expected it by cycle 33", name);
      end else begin
         checkOutput({name, " latency"}, 32'(n), 32'd33);
      end
   endtask

   // Called at the negedge of a DONE cycle: MEM takes the instruction at the
   // next edge and EXE then holds nothing.
   task automatic acceptResult();
      bus.mem_allow_in = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_allow_in = 1'b0;
      bus.exe_valid    = 1'b0;
      bus.div_req      = 1'b0;
   endtask

   task automatic applyStimulus(input logic [1:0]  op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                input logic [31:0] expected,
                                input string       name);
      startDiv(op, a, b);
      waitDone(0, name);
      checkOutput({name, " result"}, bus.div_result, expected);
      acceptResult();
   endtask

   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL watchdog: got no completion, expected finish within 500000 time units");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      reset            = 1'b1;
      bus.exe_valid    = 1'b0;
      bus.div_req      = 1'b0;
      bus.div_op       = 2'b00;
      bus.src1         = '0;
      bus.src2         = '0;
      bus.cancel       = 1'b0;
      bus.mem_allow_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      @(negedge clk);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset div_result", bus.div_result, 32'd0);
      checkOutput("reset ready_go", 32'(bus.div_ready_go), 32'd1);

      checkOutput("model div.w -7/2", modelResult(DIV_OP_DIV_W, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      checkOutput("model mod.w -7/2", modelResult(DIV_OP_MOD_W, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      checkOutput("model div.w ovf", modelResult(DIV_OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      checkOutput("model mod.w by 0", modelResult(DIV_OP_MOD_W, 32'h1234_5678, 32'd0), 32'h1234_5678);

      @(posedge clk);
      #1;
      applyStimulus(DIV_OP_DIV_W,  32'd7,         32'd2,         32'h0000_0003, "div.w 7/2");
      applyStimulus(DIV_OP_MOD_W,  32'd7,         32'd2,         32'h0000_0001, "mod.w 7/2");
      applyStimulus(DIV_OP_DIV_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div.w -7/2");
      applyStimulus(DIV_OP_MOD_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "mod.w -7/2");
      applyStimulus(DIV_OP_DIV_WU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, "div.wu max/16");
      applyStimulus(DIV_OP_DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div.w ovf");
      applyStimulus(DIV_OP_MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mod.w ovf");
      applyStimulus(DIV_OP_DIV_W,  32'h1234_5678, 32'd0,         32'hFFFF_FFFF, "div.w by 0");
      applyStimulus(DIV_OP_DIV_WU, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, "div.wu by 0");
      applyStimulus(DIV_OP_MOD_W,  32'h1234_5678, 32'd0,         32'h1234_5678, "mod.w by 0");
      applyStimulus(DIV_OP_MOD_WU, 32'h1234_5678, 32'd0,         32'h1234_5678, "mod.wu by 0");

      // Cancel while the iteration counter reads 10 (eleventh cycle after the
      // request), then issue a fresh divide on the following cycle.
      startDiv(DIV_OP_DIV_WU, 32'd1000, 32'd7);
      repeat (11) @(posedge clk);
      #1;
      bus.cancel = 1'b1;
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      bus.src1   = 32'd100;
      bus.src2   = 32'd7;
      @(negedge clk);
      checkOutput("cancel busy", 32'(bus.busy), 32'd0);
      checkOutput("cancel ready_go", 32'(bus.div_ready_go), 32'd0);
      waitDone(1, "after cancel");
      checkOutput("after cancel result", bus.div_result, 32'd14);
      acceptResult();

      // MEM stalls five DONE cycles; the result must not move.
      startDiv(DIV_OP_DIV_W, 32'd100, 32'hFFFF_FFF9);
      waitDone(0, "stall");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall div_result", bus.div_result, 32'hFFFF_FFF2);
         checkOutput("stall ready_go", 32'(bus.div_ready_go), 32'd1);
      end
      bus.mem_allow_in = 1'b1;
      @(posedge clk);
      #1;
      // Next divide loaded on the very edge that released the previous one.
      applyStimulus(DIV_OP_MOD_WU, 32'd1000, 32'd3, 32'd1, "back-to-back mod.wu");

      // Reset pulse in the middle of an iteration run.
      startDiv(DIV_OP_DIV_W, 32'd7, 32'd2);
      repeat (15) @(posedge clk);
      #1;
      reset         = 1'b1;
      bus.exe_valid = 1'b0;
      bus.div_req   = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("mid reset busy", 32'(bus.busy), 32'd0);
      checkOutput("mid reset div_result", bus.div_result, 32'd0);
      checkOutput("mid reset ready_go", 32'(bus.div_ready_go), 32'd1);
      @(posedge clk);
      #1;
      applyStimulus(DIV_OP_DIV_WU, 32'd1000, 32'd3, 32'd333, "post reset div.wu");

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_div_ctrl.md
# exe_div_ctrl

Sequencing controller for an iterative 32-bit integer divider attached to the EXE stage of the 5-stage pipeline. It detects a divide-class instruction held in EXE, runs a 32-iteration restoring division, and gates the stage's ready_go so the instruction stays in EXE until the result is available. Results are then presented to the EXE result mux. Non-divide instructions pass through with no added latency.

## Interface
Parameters:
- ITER, 32: iteration count, equal to the operand width. Fixed at 32 for this core.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- exe_valid  in  1  EXE holds a valid instruction.
- div_req  in  1  EXE instruction is div.w, mod.w, div.wu or mod.wu. Level signal, qualified by exe_valid.
- div_op  in  2  00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu.
- src1  in  32  dividend, stable while the instruction is in EXE.
- src2  in  32  divisor, stable while the instruction is in EXE.
- cancel  in  1  abort the current divide. Intended for a future flush.
- mem_allow_in  in  1  MEM accepts the EXE instruction this cycle.
- div_ready_go  out  1  ANDed into EXE ready_go.
- div_result  out  32  quotient or remainder. Valid only in DONE.
- busy  out  1  high in CALC.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - div_ready_go = ~(exe_valid & div_req).
  - If exe_valid & div_req & ~cancel, latch the following and go to CALC:
    - |src1| and |src2|; signed ops only, magnitude of 0x80000000 is 0x80000000.
    - Quotient sign = src1[31]^src2[31] (signed ops).
    - Remainder sign = src1[31] (signed ops).
    - div_op.
    - divisor_zero = (src2==0).
    - Clear the counter.
- **CALC**
  - Each cycle performs one restoring step on a 64-bit {rem, quo} register:
    - Shift left by 1.
    - Trial subtract the divisor from the upper 33 bits.
    - If the result is non-negative, keep it and set quotient bit 1.
  - The 5-bit counter increments each cycle. When the counter is 31, the step completes and the FSM goes to DONE.
- **DONE**
  - div_ready_go = 1.
  - div_result selects from the latched values:
    - Quotient for op[0]=0, remainder for op[0]=1.
    - Negated when the corresponding sign flag is set and the op is signed.
  - Hold until mem_allow_in, then go to IDLE.
- **Divide by zero** (all ops): div ops return 0xFFFFFFFF; mod ops return the latched src1 unchanged, with no sign fix.
- **Signed overflow**: 0x80000000 / 0xFFFFFFFF returns quotient 0x80000000 and remainder 0. This falls out of the magnitude algorithm; no special case.
- **cancel**: from any state, the next state is IDLE and partial results are discarded. cancel has priority over every other transition.
- **reset**: the next state is IDLE, the counter and all datapath registers clear, regardless of state.

## Timing
- Reset values:
  - state = IDLE, busy = 0, div_result = 0.
  - div_ready_go = 1 when no divide is in EXE.
- Latency, with the request first seen in IDLE at cycle 0:
  - CALC occupies cycles 1–32.
  - DONE is entered at cycle 33; div_ready_go = 1 in cycle 33.
  - Minimum EXE residency is 34 cycles.
- **Handshake**: leaving DONE coincides with the EXE register loading the next instruction, so the finished instruction is never restarted.
  - A back-to-back divide starts from IDLE on the following cycle, at most 1 bubble.
- **DONE with mem_allow_in = 0**: div_result and div_ready_go stay stable indefinitely.
- div_result is registered and has no combinational path from src1/src2.
- **div_req dropping during CALC** without cancel is illegal; an assertion flags it.

## Structure
- Shared package `cpu_pkg` holds:
  - State encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - DIV_OP constants.
- Sub-module `div_core` holds the 64-bit shift/subtract register and the counter.
  - Controls: load, step.
  - Outputs: quo, rem, last.
- exe_div_ctrl owns the FSM, the sign/zero flags, and final sign correction.

## Test plan
- div.w 7/2 → 0x00000003 with div_ready_go first high at cycle 33. mod.w 7/2 → 0x00000001.
- div.w 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. mod.w → 0xFFFFFFFF. div.wu 0xFFFFFFFF / 0x10 → 0x0FFFFFFF.
- div.w 0x80000000 / 0xFFFFFFFF → 0x80000000. mod.w → 0x00000000.
- src2 = 0, src1 = 0x12345678: div.w and div.wu → 0xFFFFFFFF; mod.w and mod.wu → 0x12345678.
- cancel asserted when the counter is 10 → IDLE next cycle, busy = 0. A new request on the following cycle completes normally.
- mem_allow_in held low 5 cycles in DONE → result stable, then IDLE. A back-to-back second divide returns the correct result. Reset pulsed mid-CALC → IDLE, div_result = 0.
